// File: rtl/sbinit_if.sv
// Sideband message types shared by the LTSM stages, plus the SB TX/RX handshake bundle.
// Latency: n/a (declarations only).
// Backpressure: TX holds msg/valid until the one-cycle sendNextFlag accept; RX pops via msg_req.
// master modport: the LTSM stage (drives TX msg/valid and RX pop request).
// slave modport:  the SB TX/RX block (drives accept, received msg and its valid).
package sbinit_pkg;

    typedef enum logic [4:0] {
        SB_NONE                = 5'd0,
        SB_SBINIT_OUT_OF_RESET = 5'd1,
        SB_SBINIT_DONE_REQ     = 5'd2,
        SB_SBINIT_DONE_RESP    = 5'd3,
        SB_MBINIT_PARAM_REQ    = 5'd4
    } SB_msg_t;

endpackage

interface sbinit_if;
    import sbinit_pkg::*;

    SB_msg_t     SB_TX_msg_o;
    logic [63:0] SB_TX_dataBus_o;
    logic        SB_TX_msg_valid_o;
    logic        SB_TX_msg_sendNextFlag_i;
    SB_msg_t     SB_RX_msg_i;
    logic [63:0] SB_RX_dataBus_i;
    logic        SB_RX_msg_req_o;
    logic        SB_RX_msg_valid_i;

    modport master (
        output SB_TX_msg_o,
        output SB_TX_dataBus_o,
        output SB_TX_msg_valid_o,
        input  SB_TX_msg_sendNextFlag_i,
        input  SB_RX_msg_i,
        input  SB_RX_dataBus_i,
        output SB_RX_msg_req_o,
        input  SB_RX_msg_valid_i
    );

    modport slave (
        input  SB_TX_msg_o,
        input  SB_TX_dataBus_o,
        input  SB_TX_msg_valid_o,
        output SB_TX_msg_sendNextFlag_i,
        output SB_RX_msg_i,
        output SB_RX_dataBus_i,
        input  SB_RX_msg_req_o,
        output SB_RX_msg_valid_i
    );

endinterface

// File: rtl/sbinit.sv
// LTSM SBINIT stage: SB clock pattern until partner detect, then OOR and DONE req/resp exchange.
// Latency: all outputs registered; OOR goes out EXTRA_ITERS full iterations after the wrap following detect.
// Backpressure: TX msg/valid held until sendNextFlag; RX is popped one message per request.
//
// Ports: clk_100MHz/reset (async, active-low); enable_i grants the stage, dropping it returns to IDLE;
// SBINIT_done_o / SBINIT_error_o levels; pattern_drive_o lane drive; pattern_detected_i from the
// RX detector; SBmessage_retry_timeout_flag in, reset_SBmessage_retry_timeout pulse out;
// sb (sbinit_if.master) carries the SB TX/RX message handshake.
// Build option: define SBINIT_PATTERN_BYPASS_EN to skip the pattern phase (ideal SB channel sims).
module sbinit #(
    parameter int ITER_CYCLES     = 96,
    parameter int EXTRA_ITERS     = 4,
    parameter int SB_PATTERN_BUSW = 1
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       enable_i,
    output logic                       SBINIT_done_o,
    output logic                       SBINIT_error_o,
    output logic [SB_PATTERN_BUSW-1:0] pattern_drive_o,
    input  logic                       pattern_detected_i,
    input  logic                       SBmessage_retry_timeout_flag,
    output logic                       reset_SBmessage_retry_timeout,
    sbinit_if.master                   sb
);
    import sbinit_pkg::*;

    localparam int CW = $clog2(ITER_CYCLES);
    localparam int IW = (EXTRA_ITERS > 1) ? $clog2(EXTRA_ITERS) : 1;
    // Clock phase of each iteration: 64 UI toggling, remaining cycles held low.
    localparam logic [CW-1:0] CLK_PHASE_CYCLES = CW'(64);
    localparam logic [CW-1:0] LAST_CYC         = CW'(ITER_CYCLES - 1);
    localparam logic [IW-1:0] LAST_ITER        = IW'(EXTRA_ITERS - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PATTERN,
        ST_EXTRA,
        ST_SEND_OOR,
        ST_WAIT_OOR,
        ST_SEND_DREQ,
        ST_WAIT_DONE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc_cnt;
    logic [IW-1:0] iter_cnt;
    logic          detected;
    logic          got_resp;
    logic          sent_resp;
    logic          resp_pend;

    logic          cyc_wrap;
    logic [CW-1:0] cyc_nxt;
    logic          tx_accept;
    logic          rx_oor;
    logic          rx_dreq;
    logic          rx_dresp;
    logic          timeout_armed;

    assign cyc_wrap  = (cyc_cnt == LAST_CYC);
    assign cyc_nxt   = cyc_wrap ? '0 : cyc_cnt + CW'(1);
    assign tx_accept = sb.SB_TX_msg_valid_o && sb.SB_TX_msg_sendNextFlag_i;
    assign rx_oor    = sb.SB_RX_msg_valid_i && (sb.SB_RX_msg_i == SB_SBINIT_OUT_OF_RESET);
    assign rx_dreq   = sb.SB_RX_msg_valid_i && (sb.SB_RX_msg_i == SB_SBINIT_DONE_REQ);
    assign rx_dresp  = sb.SB_RX_msg_valid_i && (sb.SB_RX_msg_i == SB_SBINIT_DONE_RESP);
    // The retry timer only matters while the handshake is still in progress.
    assign timeout_armed = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);

    assign sb.SB_TX_dataBus_o = '0;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state                         <= ST_IDLE;
            cyc_cnt                       <= '0;
            iter_cnt                      <= '0;
            detected                      <= 1'b0;
            got_resp                      <= 1'b0;
            sent_resp                     <= 1'b0;
            resp_pend                     <= 1'b0;
            SBINIT_done_o                 <= 1'b0;
            SBINIT_error_o                <= 1'b0;
            pattern_drive_o               <= '0;
            reset_SBmessage_retry_timeout <= 1'b0;
            sb.SB_TX_msg_o                <= SB_NONE;
            sb.SB_TX_msg_valid_o          <= 1'b0;
            sb.SB_RX_msg_req_o            <= 1'b0;
        end else begin
            reset_SBmessage_retry_timeout <= 1'b0;

            if (!enable_i) begin
                // Abort: everything back to reset values, in-flight TX is dropped unaccepted.
                state                <= ST_IDLE;
                cyc_cnt              <= '0;
                iter_cnt             <= '0;
                detected             <= 1'b0;
                got_resp             <= 1'b0;
                sent_resp            <= 1'b0;
                resp_pend            <= 1'b0;
                SBINIT_done_o        <= 1'b0;
                SBINIT_error_o       <= 1'b0;
                pattern_drive_o      <= '0;
                sb.SB_TX_msg_o       <= SB_NONE;
                sb.SB_TX_msg_valid_o <= 1'b0;
                sb.SB_RX_msg_req_o   <= 1'b0;
            end else if (timeout_armed && SBmessage_retry_timeout_flag) begin
                // Timeout wins over any message or accept seen in the same cycle.
                state                <= ST_ERR;
                SBINIT_error_o       <= 1'b1;
                pattern_drive_o      <= '0;
                sb.SB_TX_msg_o       <= SB_NONE;
                sb.SB_TX_msg_valid_o <= 1'b0;
                sb.SB_RX_msg_req_o   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        reset_SBmessage_retry_timeout <= 1'b1;
`ifdef SBINIT_PATTERN_BYPASS_EN
                        state                <= ST_SEND_OOR;
                        sb.SB_TX_msg_o       <= SB_SBINIT_OUT_OF_RESET;
                        sb.SB_TX_msg_valid_o <= 1'b1;
`else
                        state           <= ST_PATTERN;
                        cyc_cnt         <= '0;
                        pattern_drive_o <= '1;
`endif
                    end

                    ST_PATTERN: begin
                        cyc_cnt         <= cyc_nxt;
                        pattern_drive_o <= (cyc_nxt < CLK_PHASE_CYCLES) ? '1 : '0;
                        if (pattern_detected_i) begin
                            detected <= 1'b1;
                        end
                        // Finish the iteration in progress before counting extra ones.
                        if (cyc_wrap && (detected || pattern_detected_i)) begin
                            state    <= ST_EXTRA;
                            iter_cnt <= '0;
                        end
                    end

                    ST_EXTRA: begin
                        if (cyc_wrap && (iter_cnt == LAST_ITER)) begin
                            state                <= ST_SEND_OOR;
                            cyc_cnt              <= '0;
                            pattern_drive_o      <= '0;
                            sb.SB_TX_msg_o       <= SB_SBINIT_OUT_OF_RESET;
                            sb.SB_TX_msg_valid_o <= 1'b1;
                        end else begin
                            cyc_cnt         <= cyc_nxt;
                            pattern_drive_o <= (cyc_nxt < CLK_PHASE_CYCLES) ? '1 : '0;
                            if (cyc_wrap) begin
                                iter_cnt <= iter_cnt + IW'(1);
                            end
                        end
                    end

                    ST_SEND_OOR: begin
                        if (tx_accept) begin
                            state                         <= ST_WAIT_OOR;
                            sb.SB_TX_msg_o                <= SB_NONE;
                            sb.SB_TX_msg_valid_o          <= 1'b0;
                            sb.SB_RX_msg_req_o            <= 1'b1;
                            reset_SBmessage_retry_timeout <= 1'b1;
                        end
                    end

                    ST_WAIT_OOR: begin
                        // Request a pop only when no message is being presented this cycle.
                        sb.SB_RX_msg_req_o <= !sb.SB_RX_msg_valid_i;
                        if (rx_oor) begin
                            state                <= ST_SEND_DREQ;
                            sb.SB_TX_msg_o       <= SB_SBINIT_DONE_REQ;
                            sb.SB_TX_msg_valid_o <= 1'b1;
                        end
                    end

                    ST_SEND_DREQ: begin
                        // Partner may already be in its done exchange: remember its REQ/RESP.
                        sb.SB_RX_msg_req_o <= !sb.SB_RX_msg_valid_i;
                        if (rx_dresp) begin
                            got_resp <= 1'b1;
                        end
                        if (tx_accept) begin
                            state                         <= ST_WAIT_DONE;
                            reset_SBmessage_retry_timeout <= 1'b1;
                            resp_pend                     <= 1'b0;
                            if (resp_pend || rx_dreq) begin
                                sb.SB_TX_msg_o       <= SB_SBINIT_DONE_RESP;
                                sb.SB_TX_msg_valid_o <= 1'b1;
                            end else begin
                                sb.SB_TX_msg_o       <= SB_NONE;
                                sb.SB_TX_msg_valid_o <= 1'b0;
                            end
                        end else if (rx_dreq) begin
                            resp_pend <= 1'b1;
                        end
                    end

                    ST_WAIT_DONE: begin
                        sb.SB_RX_msg_req_o <= !sb.SB_RX_msg_valid_i;
                        if (got_resp && sent_resp) begin
                            state                <= ST_DONE;
                            SBINIT_done_o        <= 1'b1;
                            sb.SB_RX_msg_req_o   <= 1'b0;
                            sb.SB_TX_msg_o       <= SB_NONE;
                            sb.SB_TX_msg_valid_o <= 1'b0;
                        end else begin
                            if (rx_dresp) begin
                                got_resp <= 1'b1;
                            end
                            // Only DONE_RESP is ever in flight here; a REQ arriving with it
                            // being accepted is already answered, so it is not re-sent.
                            if (tx_accept) begin
                                sent_resp            <= 1'b1;
                                sb.SB_TX_msg_o       <= SB_NONE;
                                sb.SB_TX_msg_valid_o <= 1'b0;
                            end else if (rx_dreq && !sb.SB_TX_msg_valid_o && !sent_resp) begin
                                sb.SB_TX_msg_o       <= SB_SBINIT_DONE_RESP;
                                sb.SB_TX_msg_valid_o <= 1'b1;
                            end
                        end
                    end

                    ST_DONE: begin
                        SBINIT_done_o <= 1'b1;
                    end

                    ST_ERR: begin
                        SBINIT_error_o       <= 1'b1;
                        sb.SB_TX_msg_valid_o <= 1'b0;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sbinit.sv
// Self-checking bench for sbinit: scoreboard of expected TX messages, partner modelled inline.
// Latency: n/a.
// Backpressure: bench acts as SB TX (accept via sendNextFlag) and SB RX (one-cycle valid pulses).
module tb_sbinit;
    import sbinit_pkg::*;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       enable_i;
    logic       pattern_detected_i;
    logic       SBmessage_retry_timeout_flag;
    logic       SBINIT_done_o;
    logic       SBINIT_error_o;
    logic       reset_SBmessage_retry_timeout;
    logic [0:0] pattern_drive_o;

    int checks = 0;
    int errors = 0;
    SB_msg_t exp_q[$];
    int v_at;
    int e_at;

    sbinit_if sbi();

    sbinit #(
        .ITER_CYCLES    (96),
        .EXTRA_ITERS    (4),
        .SB_PATTERN_BUSW(1)
    ) dut (
        .clk_100MHz                   (clk_100MHz),
        .reset                        (reset),
        .enable_i                     (enable_i),
        .SBINIT_done_o                (SBINIT_done_o),
        .SBINIT_error_o               (SBINIT_error_o),
        .pattern_drive_o              (pattern_drive_o),
        .pattern_detected_i           (pattern_detected_i),
        .SBmessage_retry_timeout_flag (SBmessage_retry_timeout_flag),
        .reset_SBmessage_retry_timeout(reset_SBmessage_retry_timeout),
        .sb                           (sbi)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100MHz);
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_done"}, SBINIT_done_o, 1'b0);
        chk({tag, "_err"}, SBINIT_error_o, 1'b0);
        chk({tag, "_drv"}, pattern_drive_o, 1'b0);
        chk({tag, "_tovf"}, reset_SBmessage_retry_timeout, 1'b0);
        chk({tag, "_vld"}, sbi.SB_TX_msg_valid_o, 1'b0);
        chk({tag, "_msg"}, sbi.SB_TX_msg_o, SB_NONE);
        chk({tag, "_req"}, sbi.SB_RX_msg_req_o, 1'b0);
        chk({tag, "_data"}, sbi.SB_TX_dataBus_o, 64'd0);
    endtask

    // Runs from the first PATTERN cycle (cycle 0). Stops on TX valid or error; reports the cycle.
    task automatic pattern_phase(input string tag, input int detect_at, input int last_c,
                                 input int timeout_at, output int vld_at, output int err_at);
        vld_at = -1;
        err_at = -1;
        for (int c = 0; c <= last_c; c++) begin
            tick();
            if (c == 0) chk({tag, "_to_pulse"}, reset_SBmessage_retry_timeout, 1'b1);
            if (SBINIT_error_o) begin
                err_at = c;
                break;
            end
            if (sbi.SB_TX_msg_valid_o) begin
                vld_at = c;
                chk({tag, "_drv_off"}, pattern_drive_o, 1'b0);
                break;
            end
            chk({tag, "_drv"}, pattern_drive_o, ((c % 96) < 64) ? 64'd1 : 64'd0);
            pattern_detected_i = (c == detect_at);
            SBmessage_retry_timeout_flag = (c == timeout_at);
            if (c == detect_at) exp_q.push_back(SB_SBINIT_OUT_OF_RESET);
        end
        pattern_detected_i = 1'b0;
        SBmessage_retry_timeout_flag = 1'b0;
    endtask

    // Waits (bounded) for TX valid, compares against the scoreboard head, accepts for one cycle.
    task automatic accept_tx(input string tag);
        SB_msg_t want;
        int n;
        n = 0;
        while (!sbi.SB_TX_msg_valid_o && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, sbi.SB_TX_msg_valid_o, 1'b1);
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        want = SB_NONE;
        if (exp_q.size() != 0) want = exp_q.pop_front();
        chk({tag, "_msg"}, sbi.SB_TX_msg_o, want);
        sbi.SB_TX_msg_sendNextFlag_i = 1'b1;
        tick();
        sbi.SB_TX_msg_sendNextFlag_i = 1'b0;
    endtask

    task automatic send_rx(input SB_msg_t m);
        sbi.SB_RX_msg_i       = m;
        sbi.SB_RX_msg_valid_i = 1'b1;
        tick();
        sbi.SB_RX_msg_i       = SB_NONE;
        sbi.SB_RX_msg_valid_i = 1'b0;
    endtask

    initial begin
        reset                        = 1'b0;
        enable_i                     = 1'b0;
        pattern_detected_i           = 1'b0;
        SBmessage_retry_timeout_flag = 1'b0;
        sbi.SB_TX_msg_sendNextFlag_i = 1'b0;
        sbi.SB_RX_msg_i              = SB_NONE;
        sbi.SB_RX_dataBus_i          = 64'h0123_4567_89ab_cdef;
        sbi.SB_RX_msg_valid_i        = 1'b0;

        repeat (3) tick();
        idle_outputs("rst");
        reset = 1'b1;
        tick();
        idle_outputs("idle");

        // Normal bring-up: detect at 150 -> EXTRA at 192 -> OOR at 576.
        enable_i = 1'b1;
        pattern_phase("n", 150, 700, -1, v_at, e_at);
        chk("n_oor_cycle", v_at, 576);
        accept_tx("n_oor");
        chk("n_oor_drop", sbi.SB_TX_msg_valid_o, 1'b0);
        chk("n_oor_topulse", reset_SBmessage_retry_timeout, 1'b1);
        chk("n_rx_req", sbi.SB_RX_msg_req_o, 1'b1);
        send_rx(SB_MBINIT_PARAM_REQ);
        chk("n_discard", sbi.SB_TX_msg_valid_o, 1'b0);
        exp_q.push_back(SB_SBINIT_DONE_REQ);
        send_rx(SB_SBINIT_OUT_OF_RESET);
        accept_tx("n_dreq");
        chk("n_dreq_topulse", reset_SBmessage_retry_timeout, 1'b1);
        exp_q.push_back(SB_SBINIT_DONE_RESP);
        send_rx(SB_SBINIT_DONE_REQ);
        accept_tx("n_dresp");
        send_rx(SB_SBINIT_DONE_RESP);
        chk("n_done_early", SBINIT_done_o, 1'b0);
        tick();
        chk("n_done", SBINIT_done_o, 1'b1);
        chk("n_done_vld", sbi.SB_TX_msg_valid_o, 1'b0);
        repeat (5) tick();
        chk("n_done_hold", SBINIT_done_o, 1'b1);
        enable_i = 1'b0;
        tick();
        chk("n_leave", SBINIT_done_o, 1'b0);

        // Stall in SEND_OOR for 20 cycles, then crossed DONE messages.
        enable_i = 1'b1;
        pattern_phase("s", 5, 700, -1, v_at, e_at);
        chk("s_oor_cycle", v_at, 480);
        for (int i = 0; i < 20; i++) begin
            chk("s_stall_vld", sbi.SB_TX_msg_valid_o, 1'b1);
            chk("s_stall_msg", sbi.SB_TX_msg_o, SB_SBINIT_OUT_OF_RESET);
            tick();
        end
        accept_tx("s_oor");
        exp_q.push_back(SB_SBINIT_DONE_REQ);
        send_rx(SB_SBINIT_OUT_OF_RESET);
        chk("x_dreq_vld", sbi.SB_TX_msg_valid_o, 1'b1);
        exp_q.push_back(SB_SBINIT_DONE_RESP);
        send_rx(SB_SBINIT_DONE_REQ);
        accept_tx("x_dreq");
        chk("x_dresp_vld", sbi.SB_TX_msg_valid_o, 1'b1);
        send_rx(SB_SBINIT_DONE_RESP);
        for (int i = 0; i < 3; i++) begin
            chk("x_no_done", SBINIT_done_o, 1'b0);
            tick();
        end
        accept_tx("x_dresp");
        chk("x_done_early", SBINIT_done_o, 1'b0);
        tick();
        chk("x_done", SBINIT_done_o, 1'b1);

        // Abort in WAIT_DONE with DONE_RESP in flight.
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        pattern_phase("a", 5, 700, -1, v_at, e_at);
        accept_tx("a_oor");
        exp_q.push_back(SB_SBINIT_DONE_REQ);
        send_rx(SB_SBINIT_OUT_OF_RESET);
        accept_tx("a_dreq");
        exp_q.push_back(SB_SBINIT_DONE_RESP);
        send_rx(SB_SBINIT_DONE_REQ);
        chk("a_inflight", sbi.SB_TX_msg_valid_o, 1'b1);
        enable_i = 1'b0;
        tick();
        idle_outputs("a_abort");
        exp_q.delete();

        // Re-enable restarts at cyc_cnt 0; no detect; timeout pulse at cycle 1000.
        enable_i = 1'b1;
        pattern_phase("t", -1, 1100, 1000, v_at, e_at);
        chk("t_err_cycle", e_at, 1001);
        chk("t_err_drv", pattern_drive_o, 1'b0);
        chk("t_err_vld", sbi.SB_TX_msg_valid_o, 1'b0);
        chk("t_err_done", SBINIT_done_o, 1'b0);
        repeat (3) tick();
        chk("t_err_hold", SBINIT_error_o, 1'b1);
        enable_i = 1'b0;
        tick();
        chk("t_err_clear", SBINIT_error_o, 1'b0);

        // Async reset mid-EXTRA (cycle 150 is EXTRA, drive high).
        enable_i = 1'b1;
        pattern_phase("r", 5, 150, -1, v_at, e_at);
        chk("r_drv_before", pattern_drive_o, 1'b1);
        reset = 1'b0;
        #1;
        idle_outputs("r_async");
        tick();
        reset = 1'b1;
        enable_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbinit.md
Name: sbinit

Overview:
- LTSM SBINIT stage, directly upstream of MBINIT.
- Brings up the sideband link: sends the SB clock pattern until the partner's pattern is detected, then exchanges SBINIT out-of-reset and done req/resp messages.
- Asserts SBINIT_done_o, which the LTSM uses to enable MBINIT.
- SB message/data ports use the same SB_msg_t handshake as the other LTSM stages.

Parameters:
- ITER_CYCLES, 96: clk cycles per pattern iteration (64 UI clock + 32 UI low, counted in SB clk cycles).
- EXTRA_ITERS, 4: iterations still sent after the first detect.
- SB_PATTERN_BUSW, 1: width of pattern drive output (1 or 2 for redundant lanes).

Ports:
- clk_100MHz  in  1  SB clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_i  in  1  LTSM grants SBINIT state; low returns FSM to IDLE next cycle.
- SBINIT_done_o  out  1  level, high in DONE.
- SBINIT_error_o  out  1  level, high in ERR until enable_i drops.
- pattern_drive_o  out  SB_PATTERN_BUSW  high during pattern clock phase (first 64 cycles of each iteration).
- pattern_detected_i  in  1  pulse/level from SB RX detector: partner pattern seen.
- SB_TX_msg_o  out  SB_msg_t  message to send.
- SB_TX_dataBus_o  out  64  always 0.
- SB_TX_msg_valid_o  out  1  held high until SB_TX_msg_sendNextFlag_i.
- SB_TX_msg_sendNextFlag_i  in  1  one-cycle accept from SB TX.
- SB_RX_msg_i  in  SB_msg_t  received message.
- SB_RX_dataBus_i  in  64  ignored.
- SB_RX_msg_req_o  out  1  one-cycle pop request.
- SB_RX_msg_valid_i  in  1  SB_RX_msg_i valid this cycle.
- SBmessage_retry_timeout_flag  in  1  8 ms timeout expired.
- reset_SBmessage_retry_timeout  out  1  one-cycle pulse restarting timeout.

Behaviour:
- Reset (reset=0, async): state IDLE; counters 0; all outputs 0; SB_TX_msg_o = SB_NONE.
- States: IDLE, PATTERN, EXTRA, SEND_OOR, WAIT_OOR, SEND_DREQ, WAIT_DONE, DONE, ERR.
- IDLE -> PATTERN when enable_i=1; pulse reset_SBmessage_retry_timeout that cycle.
- PATTERN:
  - cyc_cnt 0..ITER_CYCLES-1, wraps.
  - pattern_drive_o all-ones while cyc_cnt<64, else 0.
  - First pattern_detected_i=1 latches detect; at the next wrap -> EXTRA.
- EXTRA: sends EXTRA_ITERS further complete iterations (iter_cnt 0..EXTRA_ITERS-1), then -> SEND_OOR; pattern_drive_o=0 from that cycle.
- SEND_OOR:
  - SB_TX_msg_o=SB_SBINIT_OUT_OF_RESET, valid=1.
  - On sendNextFlag: valid=0 next cycle; pulse timeout reset; -> WAIT_OOR.
- WAIT_OOR: SB_RX_msg_req_o pulses once per cycle while no valid is pending. SB_RX_msg_valid_i with SB_SBINIT_OUT_OF_RESET -> SEND_DREQ. Other messages are discarded.
- SEND_DREQ: send SB_SBINIT_DONE_REQ (same handshake) -> WAIT_DONE; timeout reset pulse.
- WAIT_DONE: tracks two flags, got_resp and sent_resp.
  - Rx SB_SBINIT_DONE_REQ: queue send of SB_SBINIT_DONE_RESP; on accept, set sent_resp.
  - Rx SB_SBINIT_DONE_RESP: set got_resp.
  - Both flags set -> DONE.
  - Rx of a message in the same cycle as TX accept: both are processed.
- DONE: SBINIT_done_o=1; stays until enable_i=0.
- Any state except IDLE/DONE/ERR: SBmessage_retry_timeout_flag=1 -> ERR. Timeout takes priority over a simultaneous message or accept.
- ERR: SBINIT_error_o=1; SB_TX_msg_valid_o=0.
- enable_i=0 in any state -> IDLE next cycle, all flags and counters cleared. An in-flight TX valid drops without waiting for accept.

Optional Feature:
- SBINIT_PATTERN_BYPASS_EN defined: IDLE -> SEND_OOR directly; pattern_drive_o tied 0; pattern_detected_i ignored. Intended for simulation with an ideal SB channel.
- Undefined: full pattern phase as above.

Test Plan:
- Normal bring-up: enable_i=1; detect at cycle 150 -> EXTRA entered at cycle 192; OOR valid at cycle 576 (192 + 4*96); partner OOR, DREQ and DRESP returned -> SBINIT_done_o=1 one cycle after both flags set.
- Crossed done messages: partner DONE_REQ arrives before our DREQ is accepted -> DRESP sent after DREQ; done only once DRESP is accepted and partner DRESP is received.
- Timeout: no detect; flag pulsed at cycle 1000 -> ERR, SBINIT_error_o=1, pattern_drive_o=0, all TX valid 0.
- Stall: sendNextFlag withheld 20 cycles in SEND_OOR -> valid and msg stable for all 20 cycles.
- Abort: enable_i=0 in WAIT_DONE -> IDLE next cycle, outputs at reset values. Re-enable restarts PATTERN at cyc_cnt=0.
- Async reset asserted mid-EXTRA -> outputs 0 immediately, with no clock edge required.
